// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, owner ids, rw codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RRESP = 2'd3
    } state_e;

    localparam logic OWNER_IC = 1'b0;
    localparam logic OWNER_DC = 1'b1;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant between icache and dcache; last winner is
// remembered only when the top level reports an accepted request.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ic_valid,
    input  logic dc_valid,
    input  logic upd_en,
    output logic ic_grant,
    output logic dc_grant,
    output logic winner
);

    logic last_grant_q;

    // On a tie the side that did not win last time goes next.
    always_comb begin
        winner = OWNER_IC;
        if (ic_valid && dc_valid)
            winner = ~last_grant_q;
        else if (dc_valid)
            winner = OWNER_DC;
        ic_grant = ic_valid && (winner == OWNER_IC);
        dc_grant = dc_valid && (winner == OWNER_DC);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_grant_q <= OWNER_IC;
        else if (upd_en)
            last_grant_q <= winner;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between icache line reads and dcache
// reads/writebacks; one transaction at a time, sequenced by a small FSM.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int BEATS      = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ic_req_valid,
    output logic                  ic_req_ready,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_resp_valid,
    output logic [DATA_WIDTH-1:0] ic_resp_data,

    input  logic                  dc_req_valid,
    output logic                  dc_req_ready,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    input  logic                  dc_req_rw,
    input  logic                  dc_wdata_valid,
    output logic                  dc_wdata_ready,
    input  logic [DATA_WIDTH-1:0] dc_wdata,
    output logic                  dc_resp_valid,
    output logic [DATA_WIDTH-1:0] dc_resp_data,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_rw,
    output logic                  mem_wdata_valid,
    input  logic                  mem_wdata_ready,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,

    output logic                  busy
);

    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  owner_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rw_q;

    logic ic_grant, dc_grant, winner, arb_en;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .ic_valid (ic_req_valid),
        .dc_valid (dc_req_valid),
        .upd_en   (arb_en),
        .ic_grant (ic_grant),
        .dc_grant (dc_grant),
        .winner   (winner)
    );

    always_comb begin
        state_d         = state_q;
        beat_cnt_d      = beat_cnt_q;
        arb_en          = 1'b0;
        ic_req_ready    = 1'b0;
        dc_req_ready    = 1'b0;
        mem_req_valid   = 1'b0;
        mem_wdata_valid = 1'b0;
        dc_wdata_ready  = 1'b0;
        ic_resp_valid   = 1'b0;
        dc_resp_valid   = 1'b0;
        case (state_q)
            // Ready is gated by reset so nothing handshakes while it is held low.
            ST_IDLE: begin
                ic_req_ready = reset && ic_grant;
                dc_req_ready = reset && dc_grant;
                if (reset && (ic_grant || dc_grant)) begin
                    arb_en  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready)
                    state_d = (rw_q == RW_WRITE) ? ST_WDATA : ST_RRESP;
            end
            ST_WDATA: begin
                mem_wdata_valid = dc_wdata_valid;
                dc_wdata_ready  = mem_wdata_ready;
                if (dc_wdata_valid && mem_wdata_ready) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            ST_RRESP: begin
                ic_resp_valid = mem_resp_valid && (owner_q == OWNER_IC);
                dc_resp_valid = mem_resp_valid && (owner_q == OWNER_DC);
                if (mem_resp_valid) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            owner_q    <= OWNER_IC;
            addr_q     <= '0;
            rw_q       <= RW_READ;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            // Icache requests are always reads whatever dc_req_rw says.
            if (arb_en) begin
                owner_q <= winner;
                addr_q  <= (winner == OWNER_DC) ? dc_req_addr : ic_req_addr;
                rw_q    <= (winner == OWNER_DC) ? dc_req_rw : RW_READ;
            end
        end
    end

    assign mem_req_addr = addr_q;
    assign mem_req_rw   = rw_q;
    assign mem_wdata    = dc_wdata;
    assign ic_resp_data = mem_resp_data;
    assign dc_resp_data = mem_resp_data;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, arbitration, read/write sequencing,
// request back-pressure and reset in the middle of a read.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req_valid, ic_req_ready, ic_resp_valid;
    logic [AW-1:0] ic_req_addr;
    logic [DW-1:0] ic_resp_data;
    logic          dc_req_valid, dc_req_ready, dc_req_rw;
    logic          dc_wdata_valid, dc_wdata_ready, dc_resp_valid;
    logic [AW-1:0] dc_req_addr;
    logic [DW-1:0] dc_wdata, dc_resp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic          mem_wdata_valid, mem_wdata_ready, mem_resp_valid;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_wdata, mem_resp_data;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .ic_req_valid    (ic_req_valid),
        .ic_req_ready    (ic_req_ready),
        .ic_req_addr     (ic_req_addr),
        .ic_resp_valid   (ic_resp_valid),
        .ic_resp_data    (ic_resp_data),
        .dc_req_valid    (dc_req_valid),
        .dc_req_ready    (dc_req_ready),
        .dc_req_addr     (dc_req_addr),
        .dc_req_rw       (dc_req_rw),
        .dc_wdata_valid  (dc_wdata_valid),
        .dc_wdata_ready  (dc_wdata_ready),
        .dc_wdata        (dc_wdata),
        .dc_resp_valid   (dc_resp_valid),
        .dc_resp_data    (dc_resp_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_req_rw      (mem_req_rw),
        .mem_wdata_valid (mem_wdata_valid),
        .mem_wdata_ready (mem_wdata_ready),
        .mem_wdata       (mem_wdata),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .busy            (busy)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // A memory beat must always land at exactly one cache while out of reset.
    always @(negedge clk) begin
        if (reset && mem_resp_valid)
            chk("resp_outside_rresp", DW'(ic_resp_valid | dc_resp_valid), 1);
    end

    // Entered at the negedge of a REQ cycle; returns at the negedge of the
    // IDLE cycle that follows the last beat.
    task automatic rd_beats(input logic to_dc, input logic [DW-1:0] base);
        mem_req_ready = 1'b1;
        adv();
        mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + DW'(b);
            settle();
            chk("rd_ic_valid", DW'(ic_resp_valid), DW'(!to_dc));
            chk("rd_dc_valid", DW'(dc_resp_valid), DW'(to_dc));
            chk("rd_data", to_dc ? dc_resp_data : ic_resp_data, base + DW'(b));
            chk("rd_no_req_ready", DW'(ic_req_ready | dc_req_ready), 0);
            adv();
        end
        mem_resp_valid = 1'b0;
        settle();
        chk("rd_done_idle", DW'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] pat;
        int idx;
        reset = 1'b0;
        ic_req_valid = 0; ic_req_addr = '0;
        dc_req_valid = 0; dc_req_addr = '0; dc_req_rw = 0;
        dc_wdata_valid = 0; dc_wdata = '0;
        mem_req_ready = 0; mem_wdata_ready = 0;
        mem_resp_valid = 0; mem_resp_data = '0;

        // Reset state, including requests presented while reset is low
        settle();
        chk("rst_busy", DW'(busy), 0);
        chk("rst_mem_req_valid", DW'(mem_req_valid), 0);
        chk("rst_addr", DW'(mem_req_addr), 0);
        chk("rst_rw", DW'(mem_req_rw), 0);
        ic_req_valid = 1; dc_req_valid = 1;
        #1;
        chk("rst_ic_ready", DW'(ic_req_ready), 0);
        chk("rst_dc_ready", DW'(dc_req_ready), 0);
        ic_req_valid = 0; dc_req_valid = 0;
        adv();
        reset = 1'b1;

        // Simultaneous requests: dcache wins the first tie
        dc_req_valid = 1; dc_req_addr = 'h100; dc_req_rw = 0;
        ic_req_valid = 1; ic_req_addr = 'h200;
        settle();
        chk("tie_dc_ready", DW'(dc_req_ready), 1);
        chk("tie_ic_ready", DW'(ic_req_ready), 0);
        adv();
        dc_req_valid = 0; dc_req_rw = 1;
        settle();
        chk("tie_req_valid", DW'(mem_req_valid), 1);
        chk("tie_addr", DW'(mem_req_addr), 'h100);
        chk("tie_rw", DW'(mem_req_rw), 0);
        chk("tie_held_ic_ready", DW'(ic_req_ready), 0);
        rd_beats(1'b1, 'hB0);
        chk("tie_ic_accept", DW'(ic_req_ready), 1);
        adv();
        ic_req_valid = 0;
        settle();
        chk("ic_addr", DW'(mem_req_addr), 'h200);
        chk("ic_rw_forced_read", DW'(mem_req_rw), 0);
        dc_req_rw = 0;
        rd_beats(1'b0, 'h10);
        adv();

        // Lone icache read
        ic_req_valid = 1; ic_req_addr = 'h40;
        settle();
        chk("lone_ic_ready", DW'(ic_req_ready), 1);
        chk("lone_dc_ready", DW'(dc_req_ready), 0);
        adv();
        ic_req_valid = 0;
        settle();
        chk("lone_req_valid", DW'(mem_req_valid), 1);
        chk("lone_addr", DW'(mem_req_addr), 'h40);
        chk("lone_rw", DW'(mem_req_rw), 0);
        chk("lone_busy", DW'(busy), 1);
        rd_beats(1'b0, 'hA0);
        adv();

        // Dcache writeback with memory write stalls
        dc_req_valid = 1; dc_req_addr = 'h300; dc_req_rw = 1;
        settle();
        chk("wb_dc_ready", DW'(dc_req_ready), 1);
        adv();
        dc_req_valid = 0; dc_req_rw = 0;
        mem_req_ready = 1;
        settle();
        chk("wb_addr", DW'(mem_req_addr), 'h300);
        chk("wb_rw", DW'(mem_req_rw), 1);
        adv();
        mem_req_ready = 0;
        dc_wdata_valid = 1;
        pat = 6'b110101;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            mem_wdata_ready = pat[c];
            dc_wdata = DW'('hC0 + idx);
            settle();
            chk("wb_wvalid", DW'(mem_wdata_valid), 1);
            chk("wb_wdata", mem_wdata, DW'('hC0 + idx));
            chk("wb_wready", DW'(dc_wdata_ready), DW'(pat[c]));
            chk("wb_busy", DW'(busy), 1);
            adv();
            if (pat[c]) idx++;
        end
        settle();
        chk("wb_done_idle", DW'(busy), 0);
        chk("wb_wvalid_idle", DW'(mem_wdata_valid), 0);
        chk("wb_wready_idle", DW'(dc_wdata_ready), 0);
        dc_wdata_valid = 0; mem_wdata_ready = 0;
        adv();

        // Request back-pressure; icache wins the tie since dcache went last
        ic_req_valid = 1; ic_req_addr = 'h440;
        dc_req_valid = 1; dc_req_addr = 'h500; dc_req_rw = 0;
        settle();
        chk("bp_ic_wins", DW'(ic_req_ready), 1);
        chk("bp_dc_waits", DW'(dc_req_ready), 0);
        adv();
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("bp_req_valid", DW'(mem_req_valid), 1);
            chk("bp_addr", DW'(mem_req_addr), 'h440);
            chk("bp_rw", DW'(mem_req_rw), 0);
            chk("bp_ic_ready", DW'(ic_req_ready), 0);
            chk("bp_dc_ready", DW'(dc_req_ready), 0);
            adv();
        end
        ic_req_valid = 0;
        settle();
        rd_beats(1'b0, 'hD0);
        chk("bp_dc_accept", DW'(dc_req_ready), 1);
        adv();
        dc_req_valid = 0;
        settle();
        chk("mid_addr", DW'(mem_req_addr), 'h500);

        // Reset during beat 2 of a dcache read
        mem_req_ready = 1;
        adv();
        mem_req_ready = 0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid = 1; mem_resp_data = DW'('hE0 + b);
            settle();
            chk("mid_dc_valid", DW'(dc_resp_valid), 1);
            adv();
        end
        mem_resp_valid = 1; mem_resp_data = 'hE2;
        reset = 1'b0;
        settle();
        chk("mid_rst_busy", DW'(busy), 0);
        chk("mid_rst_dc_valid", DW'(dc_resp_valid), 0);
        chk("mid_rst_ic_valid", DW'(ic_resp_valid), 0);
        chk("mid_rst_req_valid", DW'(mem_req_valid), 0);
        chk("mid_rst_wvalid", DW'(mem_wdata_valid), 0);
        mem_resp_valid = 0;
        adv();
        settle();
        chk("mid_rst_busy_next", DW'(busy), 0);
        chk("mid_rst_addr", DW'(mem_req_addr), 0);
        adv();
        reset = 1'b1;

        // Icache request after reset release
        ic_req_valid = 1; ic_req_addr = 'h600;
        settle();
        chk("post_ic_ready", DW'(ic_req_ready), 1);
        adv();
        ic_req_valid = 0;
        settle();
        chk("post_addr", DW'(mem_req_addr), 'h600);
        rd_beats(1'b0, 'hF0);
        adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
